// File: rtl/uvma_axis_pkt_fifo.sv
// uvma_axis_pkt_fifo: AXI-Stream beat FIFO, optional store-and-forward.
// Ports: clk, reset_n; s_* AXIS slave in; m_* AXIS master out;
//   level = beats stored, pkt_cnt = complete packets stored.

`ifndef UVMA_AXIS_TDATA_MAX_WIDTH
`define UVMA_AXIS_TDATA_MAX_WIDTH 8
`endif
`ifndef UVMA_AXIS_TUSER_MAX_WIDTH
`define UVMA_AXIS_TUSER_MAX_WIDTH 8
`endif
`ifndef UVMA_AXIS_TDEST_MAX_WIDTH
`define UVMA_AXIS_TDEST_MAX_WIDTH 8
`endif
`ifndef UVMA_AXIS_TID_MAX_WIDTH
`define UVMA_AXIS_TID_MAX_WIDTH 8
`endif

module uvma_axis_pkt_fifo #(
  parameter int TDATA_WIDTH = `UVMA_AXIS_TDATA_MAX_WIDTH,
  parameter int TUSER_WIDTH = `UVMA_AXIS_TUSER_MAX_WIDTH,
  parameter int TDEST_WIDTH = `UVMA_AXIS_TDEST_MAX_WIDTH,
  parameter int TID_WIDTH   = `UVMA_AXIS_TID_MAX_WIDTH,
  parameter int DEPTH       = 16,
  parameter int PKT_MODE    = 0,
  localparam int LW = $clog2(DEPTH+1)
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        s_tvalid,
  output logic                        s_tready,
  input  logic [TDATA_WIDTH-1:0][7:0] s_tdata,
  input  logic [TDATA_WIDTH-1:0]      s_tstrb,
  input  logic [TDATA_WIDTH-1:0]      s_tkeep,
  input  logic                        s_tlast,
  input  logic [TID_WIDTH-1:0]        s_tid,
  input  logic [TDEST_WIDTH-1:0]      s_tdest,
  input  logic [TUSER_WIDTH-1:0]      s_tuser,
  output logic                        m_tvalid,
  input  logic                        m_tready,
  output logic [TDATA_WIDTH-1:0][7:0] m_tdata,
  output logic [TDATA_WIDTH-1:0]      m_tstrb,
  output logic [TDATA_WIDTH-1:0]      m_tkeep,
  output logic                        m_tlast,
  output logic [TID_WIDTH-1:0]        m_tid,
  output logic [TDEST_WIDTH-1:0]      m_tdest,
  output logic [TUSER_WIDTH-1:0]      m_tuser,
  output logic [LW-1:0]               level,
  output logic [LW-1:0]               pkt_cnt
);

  localparam int PW = LW - 1;
  localparam int BW = 8*TDATA_WIDTH + 2*TDATA_WIDTH + 1
                    + TID_WIDTH + TDEST_WIDTH + TUSER_WIDTH;
  localparam int LAST_B = TUSER_WIDTH + TDEST_WIDTH + TID_WIDTH;
  localparam bit PKT = (PKT_MODE != 0);
  localparam logic [LW-1:0] FULL = LW'(DEPTH);

  logic [BW-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [LW-1:0] r_level;
  logic [LW-1:0] r_pkt_cnt;
  logic          r_s_tready;
  logic          r_m_tvalid;
  logic [BW-1:0] r_m_beat;
  logic          r_fwd_lock;

  logic [BW-1:0] w_s_beat;
  logic          w_push;
  logic          w_pop;
  logic          w_m_last;
  logic [LW-1:0] w_level_nxt;
  logic [LW-1:0] w_pkt_nxt;
  logic [LW-1:0] w_rem;
  logic [PW-1:0] w_rptr_nxt;
  logic [BW-1:0] w_head_nxt;
  logic          w_forced;
  logic          w_lock_nxt;
  logic          w_elig_nxt;
  logic          w_mvalid_nxt;

  assign w_s_beat = {s_tdata, s_tstrb, s_tkeep, s_tlast,
                     s_tid, s_tdest, s_tuser};

  assign w_push   = s_tvalid & r_s_tready;
  assign w_pop    = r_m_tvalid & m_tready;
  assign w_m_last = r_m_beat[LAST_B];

  always_comb begin
    w_level_nxt  = r_level + LW'(w_push) - LW'(w_pop);
    w_pkt_nxt    = r_pkt_cnt
                 + LW'(w_push & s_tlast)
                 - LW'(w_pop & w_m_last);
    w_rem        = r_level - LW'(w_pop);
    w_rptr_nxt   = r_rptr + PW'(w_pop);
    // With nothing left behind the popped head, the new head is
    // the beat being written this cycle (wptr == rptr_nxt).
    w_head_nxt   = (w_rem == '0) ? w_s_beat : r_mem[w_rptr_nxt];
    // Full with no complete packet: forward anyway, else deadlock.
    w_forced     = (r_level == FULL) && (r_pkt_cnt == '0);
    w_lock_nxt   = r_fwd_lock;
    if (w_pop && w_m_last) begin
      w_lock_nxt = 1'b0;
    end else if (w_pop && w_forced) begin
      w_lock_nxt = 1'b1;
    end
    w_elig_nxt   = !PKT
                 || (w_pkt_nxt != '0)
                 || (w_level_nxt == FULL)
                 || w_lock_nxt;
    w_mvalid_nxt = (w_level_nxt != '0) && w_elig_nxt;
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= w_s_beat;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_level    <= '0;
      r_pkt_cnt  <= '0;
      r_s_tready <= 1'b0;
      r_m_tvalid <= 1'b0;
      r_m_beat   <= '0;
      r_fwd_lock <= 1'b0;
    end else begin
      r_wptr     <= r_wptr + PW'(w_push);
      r_rptr     <= w_rptr_nxt;
      r_level    <= w_level_nxt;
      r_pkt_cnt  <= w_pkt_nxt;
      r_s_tready <= (w_level_nxt < FULL);
      r_m_tvalid <= w_mvalid_nxt;
      r_m_beat   <= w_head_nxt;
      r_fwd_lock <= w_lock_nxt;
    end
  end

  assign s_tready = r_s_tready;
  assign m_tvalid = r_m_tvalid;
  assign level    = r_level;
  assign pkt_cnt  = r_pkt_cnt;
  assign {m_tdata, m_tstrb, m_tkeep, m_tlast,
          m_tid, m_tdest, m_tuser} = r_m_beat;

endmodule

// File: tb/tb_uvma_axis_pkt_fifo.sv
// tb_uvma_axis_pkt_fifo: bench for uvma_axis_pkt_fifo.
// dut0 = first-word fall-through, dut1 = store-and-forward.

module tb_uvma_axis_pkt_fifo;

  localparam int DW    = 2;
  localparam int UW    = 3;
  localparam int DSTW  = 2;
  localparam int IW    = 2;
  localparam int DEPTH = 16;
  localparam int LW    = 5;
  localparam int BW    = 8*DW + 2*DW + 1 + IW + DSTW + UW;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic                 s_tvalid [2];
  logic                 s_tready [2];
  logic [DW-1:0][7:0]   s_tdata  [2];
  logic [DW-1:0]        s_tstrb  [2];
  logic [DW-1:0]        s_tkeep  [2];
  logic                 s_tlast  [2];
  logic [IW-1:0]        s_tid    [2];
  logic [DSTW-1:0]      s_tdest  [2];
  logic [UW-1:0]        s_tuser  [2];
  logic                 m_tvalid [2];
  logic                 m_tready [2];
  logic [DW-1:0][7:0]   m_tdata  [2];
  logic [DW-1:0]        m_tstrb  [2];
  logic [DW-1:0]        m_tkeep  [2];
  logic                 m_tlast  [2];
  logic [IW-1:0]        m_tid    [2];
  logic [DSTW-1:0]      m_tdest  [2];
  logic [UW-1:0]        m_tuser  [2];
  logic [LW-1:0]        level    [2];
  logic [LW-1:0]        pkt_cnt  [2];

  int n_vec = 0;
  int n_err = 0;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    uvma_axis_pkt_fifo #(
      .TDATA_WIDTH(DW), .TUSER_WIDTH(UW),
      .TDEST_WIDTH(DSTW), .TID_WIDTH(IW),
      .DEPTH(DEPTH), .PKT_MODE(g)
    ) u_dut (
      .clk(clk), .reset_n(reset_n),
      .s_tvalid(s_tvalid[g]), .s_tready(s_tready[g]),
      .s_tdata(s_tdata[g]), .s_tstrb(s_tstrb[g]),
      .s_tkeep(s_tkeep[g]), .s_tlast(s_tlast[g]),
      .s_tid(s_tid[g]), .s_tdest(s_tdest[g]),
      .s_tuser(s_tuser[g]),
      .m_tvalid(m_tvalid[g]), .m_tready(m_tready[g]),
      .m_tdata(m_tdata[g]), .m_tstrb(m_tstrb[g]),
      .m_tkeep(m_tkeep[g]), .m_tlast(m_tlast[g]),
      .m_tid(m_tid[g]), .m_tdest(m_tdest[g]),
      .m_tuser(m_tuser[g]),
      .level(level[g]), .pkt_cnt(pkt_cnt[g])
    );
  end

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic logic [BW-1:0] sbeat(input int g);
    return {s_tdata[g], s_tstrb[g], s_tkeep[g], s_tlast[g],
            s_tid[g], s_tdest[g], s_tuser[g]};
  endfunction

  function automatic logic [BW-1:0] mbeat(input int g);
    return {m_tdata[g], m_tstrb[g], m_tkeep[g], m_tlast[g],
            m_tid[g], m_tdest[g], m_tuser[g]};
  endfunction

  // Scoreboard: beats queued on accept, compared on pop.
  for (genvar g = 0; g < 2; g++) begin : g_mon
    logic [BW-1:0] q[$];
    int pops = 0;
    always @(negedge clk) begin
      if (!reset_n) begin
        q.delete();
      end else begin
        if (m_tvalid[g] && m_tready[g]) begin
          pops++;
          if (q.size() == 0) begin
            chk("sb_unexpected_pop", 1, 0);
          end else begin
            chk("sb_beat", mbeat(g), q.pop_front());
          end
        end
        if (s_tvalid[g] && s_tready[g]) begin
          q.push_back(sbeat(g));
        end
      end
    end
  end

  task automatic drive(input int g, input bit v,
                       input bit last, input bit rdy);
    logic [31:0] r0;
    logic [31:0] r1;
    r0 = $urandom;
    r1 = $urandom;
    s_tvalid[g] = v;
    s_tlast[g]  = last;
    m_tready[g] = rdy;
    s_tdata[g]  = r0[8*DW-1:0];
    s_tstrb[g]  = r1[DW-1:0];
    s_tkeep[g]  = r1[2*DW-1:DW];
    s_tid[g]    = r1[8+IW-1:8];
    s_tdest[g]  = r1[12+DSTW-1:12];
    s_tuser[g]  = r1[16+UW-1:16];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int g, input string nm);
    int n;
    n = 0;
    drive(g, 1'b0, 1'b0, 1'b1);
    while (level[g] != '0 && n < 64) begin
      tick();
      n++;
    end
    chk(nm, level[g], 0);
    tick();
    m_tready[g] = 1'b0;
  endtask

  typedef struct {
    bit v;
    bit last;
    bit rdy;
    int lvl;
    bit srdy;
    bit mval;
    int pkt;
  } vec_t;

  vec_t tbl[12];

  initial begin
    int  i;
    int  cyc;
    int  bad;
    int  p0;
    bit  acc;

    tbl[0]  = '{1, 1, 0, 1, 1, 1, 1};
    tbl[1]  = '{0, 0, 0, 1, 1, 1, 1};
    tbl[2]  = '{1, 0, 1, 1, 1, 1, 0};
    tbl[3]  = '{1, 1, 1, 1, 1, 1, 1};
    tbl[4]  = '{0, 0, 1, 0, 1, 0, 0};
    tbl[5]  = '{1, 1, 1, 1, 1, 1, 1};
    tbl[6]  = '{1, 0, 0, 2, 1, 1, 1};
    tbl[7]  = '{1, 1, 0, 3, 1, 1, 2};
    tbl[8]  = '{0, 0, 1, 2, 1, 1, 1};
    tbl[9]  = '{0, 0, 1, 1, 1, 1, 1};
    tbl[10] = '{0, 0, 1, 0, 1, 0, 0};
    tbl[11] = '{0, 0, 0, 0, 1, 0, 0};

    for (int g = 0; g < 2; g++) drive(g, 1'b0, 1'b0, 1'b0);
    reset_n = 1'b0;
    repeat (3) tick();

    for (int g = 0; g < 2; g++) begin
      chk("rst_s_tready", s_tready[g], 0);
      chk("rst_m_tvalid", m_tvalid[g], 0);
      chk("rst_level", level[g], 0);
      chk("rst_pkt_cnt", pkt_cnt[g], 0);
      chk("rst_m_beat", mbeat(g), 0);
    end

    @(negedge clk);
    #1 reset_n = 1'b1;
    chk("rel_s_tready_low", s_tready[0], 0);
    tick();
    chk("rel_s_tready0", s_tready[0], 1);
    chk("rel_s_tready1", s_tready[1], 1);

    // Table: FWFT push/pop patterns incl. push+pop at level 1
    for (int k = 0; k < 12; k++) begin
      drive(0, tbl[k].v, tbl[k].last, tbl[k].rdy);
      tick();
      chk("tbl_level", level[0], tbl[k].lvl);
      chk("tbl_s_tready", s_tready[0], tbl[k].srdy);
      chk("tbl_m_tvalid", m_tvalid[0], tbl[k].mval);
      chk("tbl_pkt_cnt", pkt_cnt[0], tbl[k].pkt);
    end

    // Fill to DEPTH, one pop re-opens s_tready next cycle
    for (int k = 0; k < DEPTH; k++) begin
      drive(0, 1'b1, 1'b0, 1'b0);
      tick();
      if (k == DEPTH-2) begin
        chk("t2_level15", level[0], DEPTH-1);
        chk("t2_rdy15", s_tready[0], 1);
      end
    end
    chk("t2_level_full", level[0], DEPTH);
    chk("t2_rdy_full", s_tready[0], 0);
    drive(0, 1'b1, 1'b0, 1'b1);
    tick();
    chk("t2_level_pop", level[0], DEPTH-1);
    chk("t2_rdy_pop", s_tready[0], 1);
    drive(0, 1'b1, 1'b1, 1'b0);
    tick();
    chk("t2_level_17th", level[0], DEPTH);
    chk("t2_rdy_17th", s_tready[0], 0);
    drain(0, "t2_drain");

    // Level 8 held under continuous push+pop
    for (int k = 0; k < 8; k++) begin
      drive(0, 1'b1, 1'b0, 1'b0);
      tick();
    end
    chk("t5_level8", level[0], 8);
    p0  = g_mon[0].pops;
    bad = 0;
    for (int k = 0; k < 100; k++) begin
      drive(0, 1'b1, k[0], 1'b1);
      tick();
      if (level[0] != 8 || !m_tvalid[0] || !s_tready[0]) bad++;
    end
    chk("t5_level_dev", bad, 0);
    chk("t5_pops", g_mon[0].pops - p0, 100);
    drain(0, "t5_drain");

    // Store-and-forward: 4-beat packet withheld until tlast
    for (int b = 0; b < 4; b++) begin
      drive(1, 1'b1, b == 3, 1'b0);
      tick();
      chk("t3_m_tvalid", m_tvalid[1], b == 3);
    end
    chk("t3_pkt_cnt", pkt_cnt[1], 1);
    chk("t3_level", level[1], 4);
    drain(1, "t3_drain");
    chk("t3_pkt_cnt_end", pkt_cnt[1], 0);

    // 40-beat packet through a 16-deep store-and-forward FIFO
    p0  = g_mon[1].pops;
    i   = 0;
    cyc = 0;
    while (i < 40 && cyc < 400) begin
      drive(1, 1'b1, i == 39, 1'b1);
      acc = s_tready[1];
      tick();
      if (acc) i++;
      cyc++;
    end
    chk("t4_sent", i, 40);
    drive(1, 1'b0, 1'b0, 1'b1);
    cyc = 0;
    while (level[1] != '0 && cyc < 40) begin
      tick();
      cyc++;
    end
    chk("t4_level_end", level[1], 0);
    chk("t4_no_stall", cyc <= DEPTH + 1, 1);
    chk("t4_pops", g_mon[1].pops - p0, 40);
    chk("t4_pkt_cnt", pkt_cnt[1], 0);
    tick();
    chk("t4_m_tvalid_end", m_tvalid[1], 0);
    m_tready[1] = 1'b0;

    // Reset mid-packet at level 5
    for (int k = 0; k < 5; k++) begin
      drive(0, 1'b1, 1'b0, 1'b0);
      tick();
    end
    chk("t6_level5", level[0], 5);
    chk("t6_mval5", m_tvalid[0], 1);
    reset_n = 1'b0;
    #1;
    chk("t6_rst_level", level[0], 0);
    chk("t6_rst_mval", m_tvalid[0], 0);
    chk("t6_rst_srdy", s_tready[0], 0);
    chk("t6_rst_beat", mbeat(0), 0);
    drive(0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #1 reset_n = 1'b1;
    tick();
    chk("t6_rel_srdy", s_tready[0], 1);
    drive(0, 1'b1, 1'b1, 1'b0);
    tick();
    chk("t6_fresh_level", level[0], 1);
    chk("t6_fresh_pkt", pkt_cnt[0], 1);
    p0 = g_mon[0].pops;
    drain(0, "t6_drain");
    chk("t6_fresh_pops", g_mon[0].pops - p0, 1);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
